// File: rtl/maxpool2x2.sv
// 2x2 stride-2 signed max pooling over a raster-ordered sample stream, with one line buffer of pair maxima.
// Optional build macro POOL_RELU_EN clamps negative inputs to zero before any comparison.
module maxpool2x2 #(
    parameter int DataBitWidth      = 12,
    parameter int AddressBitWidth   = 17,
    parameter int NoOfColumns       = 50,
    parameter int NoOfRows          = 50,
    parameter int ImageSizeBitWidth = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [DataBitWidth-1:0]    in_data,
    output logic                       out_we,
    output logic [AddressBitWidth-1:0] out_addr,
    output logic [DataBitWidth-1:0]    out_data,
    output logic                       ready
);

    localparam int HalfCols = ((NoOfColumns / 2) > 0) ? (NoOfColumns / 2) : 1;
    localparam int LbAw     = (HalfCols > 1) ? $clog2(HalfCols) : 1;
    localparam logic [ImageSizeBitWidth-1:0] LastCol = ImageSizeBitWidth'(NoOfColumns - 1);
    localparam logic [ImageSizeBitWidth-1:0] LastRow = ImageSizeBitWidth'(NoOfRows - 1);
    localparam logic [ImageSizeBitWidth-1:0] CntOne  = ImageSizeBitWidth'(1);
    localparam logic [AddressBitWidth-1:0]   AddrOne = AddressBitWidth'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_DONE = 3'd2
    } state_e;

    state_e                           state_q, state_d;
    logic [ImageSizeBitWidth-1:0]     col_q, col_d;
    logic [ImageSizeBitWidth-1:0]     row_q, row_d;
    logic signed [DataBitWidth-1:0]   hold_q, hold_d;
    logic                             out_we_q, out_we_d;
    logic [AddressBitWidth-1:0]       out_addr_q, out_addr_d;
    logic signed [DataBitWidth-1:0]   out_data_q, out_data_d;
    logic                             ready_q, ready_d;

    logic signed [DataBitWidth-1:0]   linebuf_q [HalfCols];
    logic signed [DataBitWidth-1:0]   x_s, pm_s, pool_s, lb_rd_s;
    logic [LbAw-1:0]                  lb_idx_s;
    logic                             lb_we_s;

    // Signed max where a tie keeps the earlier operand a.
    function automatic logic signed [DataBitWidth-1:0] max_keep_first(
        input logic signed [DataBitWidth-1:0] a,
        input logic signed [DataBitWidth-1:0] b
    );
        return (b > a) ? b : a;
    endfunction

    // Input conditioning: optional clamp of negative samples.
    always_comb begin
`ifdef POOL_RELU_EN
        if (in_data[DataBitWidth-1]) begin
            x_s = '0;
        end else begin
            x_s = $signed(in_data);
        end
`else
        x_s = $signed(in_data);
`endif
    end

    assign lb_idx_s = LbAw'(col_q >> 1);
    assign lb_rd_s  = linebuf_q[lb_idx_s];
    assign pm_s     = max_keep_first(hold_q, x_s);
    assign pool_s   = max_keep_first(lb_rd_s, pm_s);

    // Next-state, counter and output computation.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        hold_d     = hold_q;
        out_we_d   = 1'b0;
        out_addr_d = out_we_q ? (out_addr_q + AddrOne) : out_addr_q;
        out_data_d = out_data_q;
        ready_d    = 1'b0;
        lb_we_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    col_d      = '0;
                    row_d      = '0;
                    out_addr_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    if (!col_q[0]) begin
                        hold_d = x_s;
                    end else if (!row_q[0]) begin
                        lb_we_s = 1'b1;
                    end else begin
                        out_data_d = pool_s;
                        out_we_d   = 1'b1;
                    end
                    if (col_q == LastCol) begin
                        col_d = '0;
                        if (row_q == LastRow) begin
                            state_d = ST_DONE;
                        end else begin
                            row_d = row_q + CntOne;
                        end
                    end else begin
                        col_d = col_q + CntOne;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_IDLE;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            hold_q     <= '0;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            hold_q     <= hold_d;
            out_we_q   <= out_we_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            ready_q    <= ready_d;
        end
    end

    // Line buffer of even-row pair maxima; contents need no reset.
    always_ff @(posedge clk) begin
        if (lb_we_s) begin
            linebuf_q[lb_idx_s] <= pm_s;
        end
    end

    assign out_we   = out_we_q;
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_maxpool2x2.sv
// Self-checking bench for maxpool2x2: table vectors, random frames against a window-max model, reset and start corners.
module tb_maxpool2x2;
    localparam int W  = 12;
    localparam int AW = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, in_valid, sel5;
    logic [W-1:0]  in_data;
    logic          we4, we5, rdy4, rdy5;
    logic [AW-1:0] addr4, addr5;
    logic [W-1:0]  d4, d5;
    logic          out_we, ready;
    logic [AW-1:0] out_addr;
    logic [W-1:0]  out_data;

    maxpool2x2 #(.DataBitWidth(W), .AddressBitWidth(AW), .NoOfColumns(4), .NoOfRows(4),
                 .ImageSizeBitWidth(8)) dut4 (
        .clk(clk), .rst(rst), .start(start & !sel5), .in_valid(in_valid & !sel5),
        .in_data(in_data), .out_we(we4), .out_addr(addr4), .out_data(d4), .ready(rdy4));

    maxpool2x2 #(.DataBitWidth(W), .AddressBitWidth(AW), .NoOfColumns(5), .NoOfRows(5),
                 .ImageSizeBitWidth(8)) dut5 (
        .clk(clk), .rst(rst), .start(start & sel5), .in_valid(in_valid & sel5),
        .in_data(in_data), .out_we(we5), .out_addr(addr5), .out_data(d5), .ready(rdy5));

    assign out_we   = sel5 ? we5   : we4;
    assign out_addr = sel5 ? addr5 : addr4;
    assign out_data = sel5 ? d5    : d4;
    assign ready    = sel5 ? rdy5  : rdy4;

    typedef struct {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } wr_t;

    typedef struct {
        bit           five;
        int           pattern;
        int           gap_max;
        logic [W-1:0] d [4];
    } vec_t;

    wr_t          exp_q[$];
    logic [W-1:0] smp[$];
    int           rows, cols;
    int           n_cmp = 0;
    int           n_fail = 0;

`ifdef POOL_RELU_EN
    localparam logic [W-1:0] NegExp = 12'h000;
`else
    localparam logic [W-1:0] NegExp = 12'hFFD;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic signed [W-1:0] relu(input logic [W-1:0] v);
`ifdef POOL_RELU_EN
        return ($signed(v) < 0) ? '0 : $signed(v);
`else
        return $signed(v);
`endif
    endfunction

    // Reference: each output is the max of its 2x2 window, windows in raster order, floor division.
    task automatic model_frame();
        logic signed [W-1:0] best, v;
        int addr = 0;
        for (int wr = 0; wr < rows / 2; wr++) begin
            for (int wc = 0; wc < cols / 2; wc++) begin
                best = relu(smp[(2 * wr) * cols + 2 * wc]);
                for (int dr = 0; dr < 2; dr++) begin
                    for (int dc = 0; dc < 2; dc++) begin
                        v = relu(smp[(2 * wr + dr) * cols + 2 * wc + dc]);
                        if (v > best) best = v;
                    end
                end
                exp_q.push_back('{a: AW'(addr), d: best});
                addr++;
            end
        end
    endtask

    task automatic fill_ramp();
        smp.delete();
        for (int k = 0; k < rows * cols; k++) smp.push_back(W'(k));
    endtask

    // Scoreboard: every write strobe must match the next expected address/data pair.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0h data %0h, no write required", out_addr, out_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(out_addr), 32'(e.a));
                check("wr_data", 32'(out_data), 32'(e.d));
            end
        end
    end

    task automatic run_frame(input int n_send, input int gap_max, input int start_k);
        int r, c, gap;
        start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < n_send; k++) begin
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1 check("gap_we", 32'(out_we), 32'd0);
            end
            in_valid = 1'b1;
            in_data  = smp[k];
            start    = (k == start_k);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            start    = 1'b0;
            r = k / cols;
            c = k % cols;
            check("we_latency", 32'(out_we), ((r % 2 == 1) && (c % 2 == 1)) ? 32'd1 : 32'd0);
        end
        if (n_send == rows * cols) begin
            check("ready_at_last", 32'(ready), 32'd0);
            @(posedge clk);
            #1;
            check("ready_done", 32'(ready), 32'd1);
            check("we_in_done", 32'(out_we), 32'd0);
            check("writes_drained", 32'(exp_q.size()), 32'd0);
        end
    endtask

    vec_t tbl[4];

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; sel5 = 1'b0;
        #12;
        check("rst_we", 32'(out_we), 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        #10 rst = 1'b1;

        tbl[0] = '{five: 1'b0, pattern: 0, gap_max: 0, d: '{12'd5, 12'd7, 12'd13, 12'd15}};
        tbl[1] = '{five: 1'b0, pattern: 1, gap_max: 0, d: '{NegExp, NegExp, NegExp, NegExp}};
        tbl[2] = '{five: 1'b0, pattern: 0, gap_max: 3, d: '{12'd5, 12'd7, 12'd13, 12'd15}};
        tbl[3] = '{five: 1'b1, pattern: 0, gap_max: 0, d: '{12'd6, 12'd8, 12'd16, 12'd18}};

        for (int t = 0; t < 4; t++) begin
            sel5 = tbl[t].five;
            rows = sel5 ? 5 : 4;
            cols = rows;
            fill_ramp();
            if (tbl[t].pattern == 1) begin
                for (int k = 0; k < rows * cols; k++) smp[k] = 12'hFFD;
            end
            for (int i = 0; i < 4; i++) exp_q.push_back('{a: AW'(i), d: tbl[t].d[i]});
            run_frame(rows * cols, tbl[t].gap_max, -1);
            repeat (3) @(posedge clk);
            #1 check("no_extra_write", 32'(exp_q.size()), 32'd0);
        end

        // Random frames on both geometries against the model.
        for (int f = 0; f < 6; f++) begin
            sel5 = f[0];
            rows = sel5 ? 5 : 4;
            cols = rows;
            smp.delete();
            for (int k = 0; k < rows * cols; k++) smp.push_back(W'($urandom));
            model_frame();
            run_frame(rows * cols, 2, -1);
        end

        // Asynchronous reset mid-frame after 9 samples.
        sel5 = 1'b0; rows = 4; cols = 4;
        fill_ramp();
        model_frame();
        run_frame(9, 0, -1);
        #3 rst = 1'b0;
        #1;
        check("midrst_we", 32'(out_we), 32'd0);
        check("midrst_addr", 32'(out_addr), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        exp_q.delete();
        in_valid = 1'b1; in_data = 12'h7FF;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 check("idle_ignores_valid", 32'(out_we), 32'd0);
        end
        in_valid = 1'b0;
        model_frame();
        run_frame(16, 0, -1);

        // start during RUN ignored; in_valid in DONE ignored; start in DONE returns to IDLE.
        fill_ramp();
        model_frame();
        run_frame(16, 0, 6);
        in_valid = 1'b1; in_data = 12'h7FF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("done_we", 32'(out_we), 32'd0);
            check("done_ready", 32'(ready), 32'd1);
        end
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("ready_drop", 32'(ready), 32'd0);
        model_frame();
        run_frame(16, 0, -1);

        repeat (3) @(posedge clk);
        #1 check("final_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
